usr_serial_deserializer: RTL
============================

USR_SERIAL_DESERIALIZER -- requirements
Module: usr_serial_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the word width in bits; legal range 2..16.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the output buffer depth in words; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 ser_in  input  1  serial data bit; sampled only when ser_valid=1.
REQ-006 ser_valid  input  1  qualifies ser_in for the current cycle.
REQ-007 msb_first  input  1  1: first bit received lands in bit WIDTH-1 (shift-left order); 0: first bit received lands in bit 0 (shift-right order).
REQ-008 clear  input  1  synchronous abort of the partial word in progress.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  WIDTH  oldest buffered word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-013 busy  output  1  high while a partial word holds at least one bit.

Function
REQ-014 States SHALL be IDLE (bit count 0) and COLLECT (bit count 1..WIDTH-1).
- Transitions: IDLE->COLLECT on an accepted bit; COLLECT->IDLE on the WIDTH-th bit or on clear.
REQ-015 An accepted bit SHALL be ser_valid=1 AND clear=0.
REQ-016 msb_first SHALL be latched on the first bit of each word and held for the rest of that word; mid-word changes SHALL be ignored.
REQ-017 The bit counter SHALL run 0..WIDTH-1 and wrap to 0 on the WIDTH-th accepted bit.
REQ-018 On the edge that accepts the WIDTH-th bit, the assembled word SHALL be written to the buffer, and out_valid SHALL be 1 after that edge (1-cycle latency) if the buffer was empty.
REQ-019 The buffer SHALL be FIFO-ordered.
- A pop occurs on an edge where out_valid=1 and out_ready=1.
- out_data SHALL change only on a pop or on a write into an empty buffer.
REQ-020 If the buffer is full when a word completes and no pop occurs on that edge, the word SHALL be dropped, and overrun SHALL be 1 for exactly the next cycle.
REQ-021 If the buffer is full and a pop coincides with word completion, the word SHALL be written and overrun SHALL stay 0.
REQ-022 clear SHALL zero the bit counter and the partial word, return the state to IDLE, and leave the buffer untouched.
- If clear=1 together with ser_valid=1, clear wins and the bit is discarded.
REQ-023 Gaps in ser_valid SHALL NOT affect the partial word; assembly resumes at the next accepted bit.
REQ-024 busy SHALL equal (state==COLLECT).
REQ-025 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold:
- state IDLE, bit counter 0, partial word 0;
- buffer empty, with read and write pointers 0;
- out_valid=0, out_data=0, overrun=0, busy=0.
REQ-027 Assertion of rst_n mid-word or with a full buffer SHALL discard all data immediately, without waiting for a clock edge.
REQ-028 The first bit accepted after rst_n deasserts SHALL be treated as bit 0 of a new word.

Structure
REQ-029 A shared package usr_pkg SHALL hold:
- the state enum (IDLE, COLLECT);
- the default WIDTH and DEPTH constants.
REQ-030 The buffer SHALL be one sub-module, usr_word_fifo, with:
- push/pop/full/empty ports;
- pointer wrap at DEPTH;
- a count width of log2(DEPTH)+1.

Verification
REQ-031 Order check, WIDTH=4, out_ready=1.
- msb_first=1, bits 1,0,1,1 -> out_data=4'b1011 with out_valid=1 on the cycle after the 4th bit.
- msb_first=0, same bits -> out_data=4'b1101.
REQ-032 Gap tolerance: bits 1,1 then ser_valid=0 for 5 cycles, then bits 0,0 with msb_first=1 -> out_data=4'b1100; busy stays 1 during the gap.
REQ-033 Clear: after 2 bits, assert clear with ser_valid=1 -> busy=0 next cycle and no word output; the next 4 bits 0,1,1,0 (msb_first=1) -> out_data=4'b0110.
REQ-034 Overrun: out_ready=0, send three words A,B,C (DEPTH=2) -> out_valid=1 with out_data=A, overrun pulses once after C; then out_ready=1 -> A then B are popped, C is never seen.
REQ-035 Full buffer with coincident pop: buffer holds A,B; out_ready=1 on the edge C completes -> overrun=0, and the output order is A,B,C.
REQ-036 Reset mid-operation: buffer full plus 3 bits pending; pulse rst_n low asynchronously between edges -> out_valid=0 and busy=0 immediately; the next 4 bits form a correct new word.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the serial deserializer: FSM state type and
// default geometry of the word path and output buffer.
package usr_pkg;

  localparam int unsigned USR_WIDTH_DEF = 4;
  localparam int unsigned USR_DEPTH_DEF = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } usr_state_t;

endpackage

// File: rtl/usr_word_fifo.sv
// Small synchronous FIFO holding completed words. A push is honoured when
// the FIFO is not full or when a pop happens on the same edge, so a full
// buffer can still take a word while it hands one out. Read data is zero
// whenever the FIFO is empty.
module usr_word_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Word storage; contents are meaningless until written, and reads of an
  // empty buffer are masked to zero above.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/usr_serial_deserializer.sv
// Serial-to-parallel word assembler. Qualified bits are shifted into a
// partial word in the order chosen by msb_first (latched per word); each
// completed word goes into a small FIFO. Words that find the FIFO full with
// no simultaneous pop are dropped and flagged by a one-cycle overrun pulse.
module usr_serial_deserializer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEF,
  parameter int DEPTH = USR_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             msb_first,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  usr_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_msb;
  logic             r_ovr;

  logic             w_accept;
  logic             w_msb_eff;
  logic             w_complete;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_rdata;

  // Insert one bit: MSB-first shifts left (first bit ends in the top),
  // LSB-first shifts right (first bit ends in bit 0).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic b,
                                                input logic msb);
    if (msb) return {word[WIDTH-2:0], b};
    else     return {b, word[WIDTH-1:1]};
  endfunction

  // A bit on the first position of a word uses the live msb_first; later
  // bits use the value captured with that first bit.
  assign w_accept    = ser_valid & ~clear;
  assign w_msb_eff   = (r_cnt == '0) ? msb_first : r_msb;
  assign w_shift_nxt = shift_in(r_shift, ser_in, w_msb_eff);
  assign w_complete  = w_accept & (r_cnt == CNT_LAST);
  assign w_pop       = out_valid & out_ready;
  assign w_push      = w_complete & (~w_full | w_pop);

  // Word assembly FSM; clear aborts the partial word and outranks a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_msb   <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (ser_valid) begin
      if (r_cnt == '0) r_msb <= msb_first;
      if (r_cnt == CNT_LAST) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        r_state <= COLLECT;
        r_cnt   <= r_cnt + CW'(1);
        r_shift <= w_shift_nxt;
      end
    end
  end

  // Overrun pulse: a word completed into a full buffer with no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr <= 1'b0;
    else        r_ovr <= w_complete & w_full & ~w_pop;
  end

  usr_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_shift_nxt),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_data  = w_rdata;
  assign overrun   = r_ovr;
  assign busy      = (r_state == COLLECT);

endmodule
